vec_alu_seq: RTL and testbench

- Multi-cycle, parametrised vector ALU for the vector datapath execute stage.
- Accepts one V-element × N-bit operand pair plus opcode through a valid/ready handshake.
- Processes L elements per cycle over V/L beats, then holds the full result vector behind an output valid/ready handshake.
- Adds signed saturation mode and backpressure to the existing lane op set, including duplicate.

---
 rtl/vec_alu_seq.sv | 157 +++++++++++++++
 tb/tb_vec_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU for the vector execute stage.
// Takes one V-element x N-bit operand pair plus an opcode over a valid/ready handshake.
// It evaluates L elements per cycle over V/L beats, then holds the full result behind an
// output valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   A, B                 operand vectors, element i at [i*N +: N]
//   Op                   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 DUP
//   sat                  signed saturation for ADD/SUB
//   out_valid / out_ready result handshake; Result is stable while out_valid is high
//   Result               result vector, same packing as A
//   busy                 high in EXEC or DONE
module vec_alu_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned V = 16,
    parameter int unsigned L = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [V*N-1:0] A,
    input  logic [V*N-1:0] B,
    input  logic [2:0]     Op,
    input  logic           sat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [V*N-1:0] Result,
    output logic           busy
);

    localparam int unsigned Beats = V / L;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned IdxW  = $clog2(V * N);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpDup = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] beat_q;
    logic [V*N-1:0]  a_q, b_q;
    logic [2:0]      op_q;
    logic            sat_q;
    logic [V*N-1:0]  result_q, result_d;
    logic            in_ready_q, out_valid_q, busy_q;
    logic            last_beat;

    // One element of the datapath; dup is A[i/2], which may lie outside the current slice.
    function automatic logic [N-1:0] lane_op(input logic [2:0] op, input logic s,
                                             input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] dup);
        logic [N:0]   ext;
        logic [N-1:0] r;
        ext = '0;
        r   = '0;
        case (op)
            OpAdd, OpSub: begin
                ext = (op == OpAdd) ? ({a[N-1], a} + {b[N-1], b})
                                    : ({a[N-1], a} - {b[N-1], b});
                r   = ext[N-1:0];
                // Signed overflow iff the extended sign bit disagrees with the result sign.
                if (s && (ext[N] != ext[N-1])) begin
                    r = ext[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                end
            end
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpXor:   r = a ^ b;
            OpShl:   r = a << b[3:0];
            OpShr:   r = $signed(a) >>> b[3:0];
            OpDup:   r = dup;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign last_beat = (beat_q == CntW'(Beats - 1));

    always_comb begin
        logic [IdxW-1:0] base;
        logic [IdxW-1:0] dbase;
        result_d = result_q;
        base     = '0;
        dbase    = '0;
        for (int unsigned l = 0; l < L; l++) begin
            base  = IdxW'((32'(beat_q) * L + l) * N);
            dbase = IdxW'(((32'(beat_q) * L + l) >> 1) * N);
            result_d[base +: N] = lane_op(op_q, sat_q, a_q[base +: N], b_q[base +: N],
                                          a_q[dbase +: N]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            sat_q       <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        op_q       <= Op;
                        sat_q      <= sat;
                        beat_q     <= '0;
                        state_q    <= StExec;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StExec: begin
                    result_q <= result_d;
                    if (last_beat) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                StDone: begin
                    // A concurrent in_valid is not taken here; in_ready rises first.
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Result    = result_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: three builds (L=4, L=16, L=1) share operand inputs
// and are checked against a per-element arithmetic reference model.
module tb_vec_alu_seq;

    localparam int unsigned N = 16;
    localparam int unsigned V = 16;
    localparam int unsigned W = V * N;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    logic [W-1:0] A, B;
    logic [2:0]   Op;
    logic         sat;
    logic [2:0]   in_ready_w, out_valid_w, busy_w;
    logic [W-1:0] res [3];

    int vectors;
    int miscompares;

    vec_alu_seq #(.N(N), .V(V), .L(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .A(A), .B(B), .Op(Op), .sat(sat), .out_valid(out_valid_w[0]),
        .out_ready(out_ready[0]), .Result(res[0]), .busy(busy_w[0])
    );
    vec_alu_seq #(.N(N), .V(V), .L(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .A(A), .B(B), .Op(Op), .sat(sat), .out_valid(out_valid_w[1]),
        .out_ready(out_ready[1]), .Result(res[1]), .busy(busy_w[1])
    );
    vec_alu_seq #(.N(N), .V(V), .L(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .A(A), .B(B), .Op(Op), .sat(sat), .out_valid(out_valid_w[2]),
        .out_ready(out_ready[2]), .Result(res[2]), .busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [N-1:0] e);
        logic [W-1:0] r;
        for (int i = 0; i < V; i++) r[i*N +: N] = e;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: each element from plain signed integer arithmetic, then truncated to N bits.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic s);
        logic [W-1:0] r;
        int ea, eb, sh, x;
        int hi, lo;
        hi = (1 << (N - 1)) - 1;
        lo = -(1 << (N - 1));
        for (int i = 0; i < V; i++) begin
            ea = $signed(a[i*N +: N]);
            eb = $signed(b[i*N +: N]);
            sh = int'(b[i*N +: 4]);
            case (op)
                3'd0: x = ea + eb;
                3'd1: x = ea - eb;
                3'd2: x = ea & eb;
                3'd3: x = ea | eb;
                3'd4: x = ea ^ eb;
                3'd5: x = ea << sh;
                3'd6: x = ea >>> sh;
                default: x = $signed(a[(i/2)*N +: N]);
            endcase
            if (s && op <= 3'd1) begin
                if (x > hi) x = hi;
                if (x < lo) x = lo;
            end
            r[i*N +: N] = x[N-1:0];
        end
        return r;
    endfunction

    function automatic int exp_lat(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 16;
    endfunction

    // Full transaction on build d; operands are scrambled right after accept.
    task automatic xact(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic s, input int hold);
        logic [W-1:0] exp;
        int lat;
        exp = model(a, b, op, s);
        @(negedge clk);
        A = a; B = b; Op = op; sat = s;
        in_valid[d] = 1'b1;
        check_bit("in_ready_idle", in_ready_w[d], 1'b1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        A = ~a; B = ~b; Op = op ^ 3'b101; sat = ~s;
        lat = 0;
        while (!out_valid_w[d] && lat < 40) begin
            check_bit("in_ready_exec", in_ready_w[d], 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", W'(lat), W'(exp_lat(d)));
        check("result", res[d], exp);
        check_bit("in_ready_done", in_ready_w[d], 1'b0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_result", res[d], exp);
            check_bit("hold_valid", out_valid_w[d], 1'b1);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check_bit("release_in_ready", in_ready_w[d], 1'b1);
        check_bit("release_out_valid", out_valid_w[d], 1'b0);
        check_bit("release_busy", busy_w[d], 1'b0);
        check("idle_result_hold", res[d], exp);
    endtask

    initial begin
        logic [W-1:0] a, b, a2, b2, dexp;
        logic [2:0]   op;
        logic         s;
        int           lat;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        A = '0; B = '0; Op = '0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_bit("reset_in_ready", in_ready_w[d], 1'b1);
            check_bit("reset_out_valid", out_valid_w[d], 1'b0);
            check_bit("reset_busy", busy_w[d], 1'b0);
            check("reset_result", res[d], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases on the default build.
        xact(0, rep(16'h7fff), rep(16'h0001), 3'd0, 1'b0, 0);
        check("add_wrap", res[0], rep(16'h8000));
        xact(0, rep(16'h7fff), rep(16'h0001), 3'd0, 1'b1, 5);
        check("add_sat", res[0], rep(16'h7fff));
        xact(0, rep(16'h8000), rep(16'h0001), 3'd1, 1'b1, 0);
        check("sub_sat", res[0], rep(16'h8000));
        for (int i = 0; i < V; i++) begin
            a[i*N +: N]    = 16'h0100 + 16'(i);
            dexp[i*N +: N] = 16'h0100 + 16'(i / 2);
        end
        xact(0, a, rand_vec(), 3'd7, 1'b1, 0);
        check("dup", res[0], dexp);
        xact(0, rep(16'h8001), rep(16'h0004), 3'd6, 1'b0, 0);
        check("shr", res[0], rep(16'hf800));
        xact(0, rep(16'h8001), rep(16'h0004), 3'd5, 1'b0, 0);
        check("shl", res[0], rep(16'h0010));

        // in_valid together with out_ready in DONE: release first, accept one cycle later.
        a = rand_vec(); b = rand_vec();
        @(negedge clk);
        A = a; B = b; Op = 3'd0; sat = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid_w[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_bit("simul_done", out_valid_w[0], 1'b1);
        a2 = rand_vec(); b2 = rand_vec();
        @(negedge clk);
        A = a2; B = b2; Op = 3'd4; sat = 1'b0;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check_bit("simul_not_busy", busy_w[0], 1'b0);
        check_bit("simul_in_ready", in_ready_w[0], 1'b1);
        check_bit("simul_out_valid", out_valid_w[0], 1'b0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check_bit("simul_accept_busy", busy_w[0], 1'b1);
        check_bit("simul_accept_in_ready", in_ready_w[0], 1'b0);
        lat = 0;
        while (!out_valid_w[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("simul_latency", W'(lat), W'(4));
        check("simul_result", res[0], model(a2, b2, 3'd4, 1'b0));
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;

        // Asynchronous reset partway through EXEC.
        @(negedge clk);
        A = rand_vec(); B = rand_vec(); Op = 3'd0; sat = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("midrst_out_valid", out_valid_w[0], 1'b0);
        check_bit("midrst_in_ready", in_ready_w[0], 1'b1);
        check_bit("midrst_busy", busy_w[0], 1'b0);
        check("midrst_result", res[0], '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random vectors through all three builds; results must agree with each other too.
        for (int t = 0; t < 15; t++) begin
            a  = rand_vec();
            b  = rand_vec();
            op = 3'($urandom_range(0, 7));
            s  = 1'($urandom_range(0, 1));
            for (int d = 0; d < 3; d++) xact(d, a, b, op, s, 0);
            check("cross_l16", res[1], res[0]);
            check("cross_l1", res[2], res[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
